uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm_if.sv | 34 +++
 rtl/uart_rx_fsm.sv | 117 +++++++++++
 tb/tb_uart_rx_fsm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_if.sv
// Control/status bundle between the UART receive FSM and its edge/bit counter,
// sampler, deserializer and check blocks.
interface uart_rx_fsm_if #(
   parameter int unsigned PRESCALE_W = 6
);
   logic                  RX_IN;
   logic                  PAR_EN;
   logic [PRESCALE_W-1:0] PRESCALE;
   logic [3:0]            BIT_CNT;
   logic [PRESCALE_W-1:0] EDGE_CNT;
   logic                  STRT_GLITCH;
   logic                  PAR_ERR;
   logic                  STP_ERR;
   logic                  CNT_EN;
   logic                  SMPL_EN;
   logic                  DESER_EN;
   logic                  STRT_CHK_EN;
   logic                  PAR_CHK_EN;
   logic                  STP_CHK_EN;
   logic                  DATA_VALID;
   logic                  FRAME_ERR;

   modport slave (
      input  RX_IN, PAR_EN, PRESCALE, BIT_CNT, EDGE_CNT, STRT_GLITCH, PAR_ERR, STP_ERR,
      output CNT_EN, SMPL_EN, DESER_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN,
             DATA_VALID, FRAME_ERR
   );

   modport master (
      output RX_IN, PAR_EN, PRESCALE, BIT_CNT, EDGE_CNT, STRT_GLITCH, PAR_ERR, STP_ERR,
      input  CNT_EN, SMPL_EN, DESER_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN,
             DATA_VALID, FRAME_ERR
   );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: sequences start/data/parity/stop bits and strobes.
// Parity support is built only when UART_RX_PARITY_EN is defined.
module uart_rx_fsm #(
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic          CLK,
   input  logic          RST,
   uart_rx_fsm_if.slave  bus
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, ERR_CHK} state_e;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, ERR_CHK} state_e;
`endif

   state_e state_q, state_d;
   logic   last;
   logic   frame_bad;

   assign last = (bus.EDGE_CNT == (bus.PRESCALE - PRESCALE_W'(1)));

`ifdef UART_RX_PARITY_EN
   logic par_en_q, par_en_d;
   assign frame_bad = bus.PAR_ERR | bus.STP_ERR;
`else
   logic unused_par;
   assign unused_par = bus.PAR_EN ^ bus.PAR_ERR;
   assign frame_bad  = bus.STP_ERR;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
`ifdef UART_RX_PARITY_EN
         par_en_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
`ifdef UART_RX_PARITY_EN
         par_en_q <= par_en_d;
`endif
      end
   end

   always_comb begin
      state_d         = state_q;
`ifdef UART_RX_PARITY_EN
      par_en_d        = par_en_q;
`endif
      bus.CNT_EN      = 1'b0;
      bus.SMPL_EN     = 1'b0;
      bus.DESER_EN    = 1'b0;
      bus.STRT_CHK_EN = 1'b0;
      bus.PAR_CHK_EN  = 1'b0;
      bus.STP_CHK_EN  = 1'b0;
      bus.DATA_VALID  = 1'b0;
      bus.FRAME_ERR   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!bus.RX_IN) begin
               state_d  = START;
`ifdef UART_RX_PARITY_EN
               par_en_d = bus.PAR_EN;
`endif
            end
         end
         START: begin
            bus.CNT_EN      = 1'b1;
            bus.SMPL_EN     = 1'b1;
            bus.STRT_CHK_EN = last;
            if (last) state_d = bus.STRT_GLITCH ? IDLE : DATA;
         end
         DATA: begin
            bus.CNT_EN   = 1'b1;
            bus.SMPL_EN  = 1'b1;
            bus.DESER_EN = last;
            if (last && (bus.BIT_CNT == 4'd8)) begin
`ifdef UART_RX_PARITY_EN
               state_d = par_en_q ? PARITY : STOP;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            bus.CNT_EN     = 1'b1;
            bus.SMPL_EN    = 1'b1;
            bus.PAR_CHK_EN = last;
            if (last) state_d = STOP;
         end
`endif
         STOP: begin
            bus.CNT_EN     = 1'b1;
            bus.SMPL_EN    = 1'b1;
            bus.STP_CHK_EN = last;
            if (last) state_d = ERR_CHK;
         end
         ERR_CHK: begin
            // Single-cycle verdict; a low line here is the next frame's start bit.
            bus.DATA_VALID = ~frame_bad;
            bus.FRAME_ERR  = frame_bad;
            if (!bus.RX_IN) begin
               state_d  = START;
`ifdef UART_RX_PARITY_EN
               par_en_d = bus.PAR_EN;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed self-checking bench for uart_rx_fsm with a behavioural edge/bit counter.
module tb_uart_rx_fsm;
   localparam int unsigned PW = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_rx_fsm_if #(.PRESCALE_W(PW)) bus();
   uart_rx_fsm #(.PRESCALE_W(PW)) dut (.CLK(clk), .RST(rst), .bus(bus));

   int unsigned npass  = 0;
   int unsigned ntotal = 0;
   int unsigned deser_n, strt_n, par_n, stp_n, dv_n, fe_n;
   logic [3:0]  par_bit;
   logic        clr;

   // Edge/bit counter: clears whenever CNT_EN is low, BIT_CNT 0 is the start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.EDGE_CNT <= '0;
         bus.BIT_CNT  <= '0;
      end else if (!bus.CNT_EN) begin
         bus.EDGE_CNT <= '0;
         bus.BIT_CNT  <= '0;
      end else if (bus.EDGE_CNT == bus.PRESCALE - PW'(1)) begin
         bus.EDGE_CNT <= '0;
         bus.BIT_CNT  <= bus.BIT_CNT + 4'd1;
      end else begin
         bus.EDGE_CNT <= bus.EDGE_CNT + PW'(1);
      end
   end

   always @(posedge clk) begin
      if (clr) begin
         deser_n = 0; strt_n = 0; par_n = 0; stp_n = 0; dv_n = 0; fe_n = 0;
         par_bit = '0;
      end else begin
         if (bus.DESER_EN)    deser_n++;
         if (bus.STRT_CHK_EN) strt_n++;
         if (bus.PAR_CHK_EN)  begin par_n++; par_bit = bus.BIT_CNT; end
         if (bus.STP_CHK_EN)  stp_n++;
         if (bus.DATA_VALID)  dv_n++;
         if (bus.FRAME_ERR)   fe_n++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic clear_counts();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
   endtask

   // Leaves the bench at the first negedge after the FSM entered START.
   task automatic start_frame(input logic [PW-1:0] p, input logic pe);
      @(negedge clk);
      bus.PRESCALE = p;
      bus.PAR_EN   = pe;
      bus.RX_IN    = 1'b0;
      @(negedge clk);
      bus.RX_IN    = 1'b1;
   endtask

   initial begin
      rst = 1'b0; clr = 1'b1;
      bus.RX_IN = 1'b0; bus.PAR_EN = 1'b1; bus.PRESCALE = PW'(8);
      bus.STRT_GLITCH = 1'b0; bus.PAR_ERR = 1'b0; bus.STP_ERR = 1'b0;

      // Reset: line low must not start a frame while held in reset
      repeat (3) @(negedge clk);
      chk("rst_cnt_en",  32'(bus.CNT_EN), 0);
      chk("rst_smpl_en", 32'(bus.SMPL_EN), 0);
      chk("rst_dv",      32'(bus.DATA_VALID), 0);
      chk("rst_fe",      32'(bus.FRAME_ERR), 0);
      @(negedge clk); rst = 1'b1; bus.RX_IN = 1'b1; clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_after_rst", 32'(bus.CNT_EN), 0);

      // PRESCALE 8, no parity, good stop
      clear_counts();
      start_frame(PW'(8), 1'b0);
      chk("a_start_cnt_en", 32'(bus.CNT_EN), 1);
      repeat (79) @(negedge clk);
      chk("a_stop_busy", 32'(bus.CNT_EN), 1);
      @(negedge clk);
      chk("a_dv",      32'(bus.DATA_VALID), 1);
      chk("a_fe",      32'(bus.FRAME_ERR), 0);
      chk("a_errchk_cnt_en", 32'(bus.CNT_EN), 0);
      chk("a_deser_n", deser_n, 8);
      chk("a_strt_n",  strt_n, 1);
      chk("a_stp_n",   stp_n, 1);
      @(negedge clk);
      chk("a_dv_drop", 32'(bus.DATA_VALID), 0);
      chk("a_dv_n",    dv_n, 1);
      chk("a_fe_n",    fe_n, 0);

`ifdef UART_RX_PARITY_EN
      // PRESCALE 16, parity on, parity error; PAR_EN dropped mid-frame
      clear_counts();
      bus.PAR_ERR = 1'b1;
      start_frame(PW'(16), 1'b1);
      bus.PAR_EN = 1'b0;
      repeat (11 * 16) @(negedge clk);
      chk("b_fe",      32'(bus.FRAME_ERR), 1);
      chk("b_dv",      32'(bus.DATA_VALID), 0);
      chk("b_par_n",   par_n, 1);
      chk("b_par_bit", 32'(par_bit), 9);
      chk("b_deser_n", deser_n, 8);
      @(negedge clk);
      bus.PAR_ERR = 1'b0;
      chk("b_fe_n", fe_n, 1);
`else
      // Parity compiled out: PAR_EN and PAR_ERR have no effect
      clear_counts();
      bus.PAR_ERR = 1'b1;
      start_frame(PW'(16), 1'b1);
      repeat (10 * 16) @(negedge clk);
      chk("b_dv",      32'(bus.DATA_VALID), 1);
      chk("b_fe",      32'(bus.FRAME_ERR), 0);
      chk("b_par_n",   par_n, 0);
      chk("b_deser_n", deser_n, 8);
      @(negedge clk);
      bus.PAR_ERR = 1'b0;
`endif

      // PRESCALE 32, stop error
      clear_counts();
      bus.STP_ERR = 1'b1;
      start_frame(PW'(32), 1'b0);
      repeat (10 * 32) @(negedge clk);
      chk("c_fe", 32'(bus.FRAME_ERR), 1);
      chk("c_dv", 32'(bus.DATA_VALID), 0);
      @(negedge clk);
      bus.STP_ERR = 1'b0;
      chk("c_fe_n", fe_n, 1);

      // Start glitch: line low two cycles, glitch flagged at START last edge
      clear_counts();
      @(negedge clk);
      bus.PRESCALE = PW'(8); bus.STRT_GLITCH = 1'b1; bus.RX_IN = 1'b0;
      @(negedge clk);
      @(negedge clk); bus.RX_IN = 1'b1;
      repeat (6) @(negedge clk);
      chk("d_start_last", 32'(bus.STRT_CHK_EN), 1);
      @(negedge clk);
      chk("d_back_idle", 32'(bus.CNT_EN), 0);
      repeat (20) @(negedge clk);
      bus.STRT_GLITCH = 1'b0;
      chk("d_deser_n", deser_n, 0);
      chk("d_dv_n",    dv_n, 0);
      chk("d_strt_n",  strt_n, 1);

      // Back-to-back frames
      clear_counts();
      start_frame(PW'(8), 1'b0);
      repeat (10 * 8) @(negedge clk);
      chk("e_dv1", 32'(bus.DATA_VALID), 1);
      bus.RX_IN = 1'b0;
      @(negedge clk);
      bus.RX_IN = 1'b1;
      chk("e_direct_start", 32'(bus.CNT_EN), 1);
      repeat (10 * 8) @(negedge clk);
      chk("e_dv2", 32'(bus.DATA_VALID), 1);
      @(negedge clk);
      chk("e_dv_n",    dv_n, 2);
      chk("e_deser_n", deser_n, 16);
      chk("e_idle",    32'(bus.CNT_EN), 0);

      // Reset mid-frame at BIT_CNT 4
      clear_counts();
      start_frame(PW'(8), 1'b0);
      for (int i = 0; i < 100 && bus.BIT_CNT != 4'd4; i++) @(negedge clk);
      chk("f_reach_bit4", 32'(bus.BIT_CNT), 4);
      chk("f_deser_pre",  deser_n, 3);
      rst = 1'b0;
      #1;
      chk("f_rst_cnt_en",  32'(bus.CNT_EN), 0);
      chk("f_rst_smpl_en", 32'(bus.SMPL_EN), 0);
      chk("f_rst_deser",   32'(bus.DESER_EN), 0);
      @(negedge clk); rst = 1'b1;
      repeat (120) @(negedge clk);
      chk("f_dv_n",   dv_n, 0);
      chk("f_fe_n",   fe_n, 0);
      chk("f_idle",   32'(bus.CNT_EN), 0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
